md_ctrl: RTL and testbench
==========================

Name: md_ctrl

Overview:
- Controller that sequences the shared multiply/divide datapath for the pipeline.
- Sits in the E stage. It decodes mult/multu/div/divu/mthi/mtlo/mfhi/mflo requests, drives the datapath's valid/ready handshake and owns the architectural HI/LO registers.
- It also generates the pipeline stall signal and gates issue on exception flush.
- It counts datapath-busy cycles for performance monitoring.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- PERF_EN, 1, when 1 the busy-cycle counter is implemented; when 0, perf_busy_cycles is tied to 0.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- e_md_op  input  4  request code, from the shared package: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
- e_valid  input  1  the E-stage instruction is real (not a bubble).
- flush  input  1  exception/eret cancels the E-stage instruction this cycle.
- e_rs  input  WIDTH  source 0 (dividend / multiplicand / mthi-mtlo data).
- e_rt  input  WIDTH  source 1.
- md_stall  output  1  freeze the F/D/E stages.
- hi_out  output  WIDTH  current HI value, for mfhi.
- lo_out  output  WIDTH  current LO value, for mflo.
- md_in_src0  output  WIDTH  to datapath.
- md_in_src1  output  WIDTH  to datapath.
- md_in_op  output  2  to datapath: IDLE=00, MUL=01, DIV=10.
- md_in_sign  output  1  to datapath.
- md_in_valid  output  1  to datapath.
- md_in_ready  input  1  from datapath.
- md_out_valid  input  1  from datapath.
- md_out_ready  output  1  to datapath.
- md_out_res0  input  WIDTH  LO-bound result: low product, or quotient.
- md_out_res1  input  WIDTH  HI-bound result: high product, or remainder.
- perf_busy_cycles  output  32  number of cycles spent in BUSY.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. On reset:
  - state=IDLE, HI=0, LO=0, perf_busy_cycles=0.
  - md_in_valid=0, md_stall=0.
  - The datapath shares the same reset, so an in-flight operation is abandoned with no HI/LO write.
- issue = e_valid & !flush & (e_md_op in MULT..DIVU).
- md_in_src0=e_rs and md_in_src1=e_rt at all times.
- md_in_op=MUL for MULT/MULTU, DIV for DIV/DIVU, otherwise IDLE.
- md_in_sign=1 for MULT/DIV only.
- FSM has two states, IDLE and BUSY.
  - IDLE:
    - md_in_valid = issue & md_in_ready (combinational).
    - On md_in_valid & md_in_ready: next state is BUSY and the issuing instruction proceeds (no stall).
    - If issue & !md_in_ready, which is illegal in IDLE: hold md_stall=1 and stay in IDLE.
  - BUSY:
    - md_out_ready=1; md_in_valid=0.
    - On md_out_valid: HI<=md_out_res1, LO<=md_out_res0, next state is IDLE.
- md_out_ready=0 in IDLE.
- md_stall=1 when state==BUSY & e_valid & e_md_op!=NONE, including the completion cycle. This means mfhi/mflo never read stale HI/LO and no forwarding is needed. Non-md instructions are never stalled.
- mthi/mtlo (e_valid & !flush, IDLE): HI or LO <= e_rs at the next edge. While BUSY these stall like any other md op.
- hi_out/lo_out are the register values, combinational read; there is no bypass of the in-cycle write.
- flush:
  - Suppresses issue and mthi/mtlo writes in that cycle.
  - Does not cancel an already accepted operation, which completes and writes HI/LO (MIPS semantics).
  - flush has no effect on md_stall, which is driven by e_valid.
- Divide by zero: no special handling; the datapath result is written unchanged.
- Latency:
  - Mult: accept edge, then md_out_valid the next cycle; HI/LO are visible 2 cycles after issue.
  - Div: variable, bounded by the datapath.
- perf_busy_cycles increments by 1 in every BUSY cycle and wraps modulo 2^32.

Decomposition:
- Shared package md_pkg holds the e_md_op codes, the datapath op codes (IDLE/MUL/DIV) and the FSM state encoding.
- One sub-module is natural: md_hilo_regfile, holding the HI/LO registers with their write-select logic. It takes the datapath result, mthi/mtlo writes and reset; a datapath result and an mt write can never coincide.
- The FSM, decode and stall logic stay at top level.

Test Plan:
- MULT e_rs=0xFFFFFFFD (-3), e_rt=5 -> one accepted handshake; after completion HI=0xFFFFFFFF, LO=0xFFFFFFF1; md_stall=0 on the issue cycle.
- DIVU 7/2, then MFLO back-to-back -> md_stall=1 until completion; then lo_out=3 and hi_out=1.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; perf_busy_cycles equals the number of BUSY cycles observed.
- MULTU issued with flush=1 -> md_in_valid=0, state stays IDLE, HI/LO unchanged (0).
- MTHI 0x12345678 while IDLE, then MFHI -> hi_out=0x12345678. MTLO issued during BUSY -> stalls, then writes LO after the datapath result, so the final LO is the mt value.
- Reset asserted mid-DIV -> next cycle state=IDLE, HI=LO=0, md_stall=0. A subsequent MULT 6*7 then gives LO=42, HI=0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide controller.
//   md_op_e    : E-stage request codes decoded by md_ctrl
//   dp_op_e    : operation codes driven to the shared mul/div datapath
//   md_state_e : controller FSM state encoding
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        DP_IDLE = 2'b00,
        DP_MUL  = 2'b01,
        DP_DIV  = 2'b10
    } dp_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // True for the four codes that need the datapath (MULT..DIVU).
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/md_if.sv
// Valid/ready link between md_ctrl (master) and the shared mul/div datapath (slave).
//   md_in_*  : operands, op code and sign, with the request handshake
//   md_out_* : result handshake; res0 is LO-bound, res1 is HI-bound
interface md_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] md_in_src0;
    logic [WIDTH-1:0] md_in_src1;
    logic [1:0]       md_in_op;
    logic             md_in_sign;
    logic             md_in_valid;
    logic             md_in_ready;
    logic             md_out_valid;
    logic             md_out_ready;
    logic [WIDTH-1:0] md_out_res0;
    logic [WIDTH-1:0] md_out_res1;

    modport master (
        output md_in_src0, md_in_src1, md_in_op, md_in_sign, md_in_valid, md_out_ready,
        input  md_in_ready, md_out_valid, md_out_res0, md_out_res1
    );

    modport slave (
        input  md_in_src0, md_in_src1, md_in_op, md_in_sign, md_in_valid, md_out_ready,
        output md_in_ready, md_out_valid, md_out_res0, md_out_res1
    );
endinterface

// File: rtl/md_hilo_regfile.sv
// Architectural HI/LO registers.
//   clk, reset        : clock, synchronous active-high reset (clears HI/LO)
//   res_we            : write datapath result (res_hi -> HI, res_lo -> LO)
//   mthi_we, mtlo_we  : write mt_data into HI or LO
//   hi, lo            : current register values
// A datapath result and an mt write never coincide (mt ops stall while the
// datapath is busy), so the result write simply takes priority.
module md_hilo_regfile #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             res_we,
    input  logic [WIDTH-1:0] res_hi,
    input  logic [WIDTH-1:0] res_lo,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] mt_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (res_we) begin
            hi <= res_hi;
            lo <= res_lo;
        end else begin
            if (mthi_we) hi <= mt_data;
            if (mtlo_we) lo <= mt_data;
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// E-stage multiply/divide controller: decodes md requests, runs the datapath
// handshake, owns HI/LO, stalls F/D/E while the datapath is busy and counts
// busy cycles.
//   clk, reset            : clock, synchronous active-high reset
//   e_md_op, e_valid      : E-stage request code and instruction-valid
//   flush                 : cancels the E-stage instruction this cycle
//   e_rs, e_rt            : source operands
//   md_stall              : freeze F/D/E
//   hi_out, lo_out        : architectural HI/LO
//   dp                    : datapath link (md_if master)
//   perf_busy_cycles      : cycles spent in BUSY (0 when PERF_EN=0)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | datapath free; mul/div may issue, mthi/mtlo write directly
// ST_BUSY | operation accepted; waiting for md_out_valid, md ops stall
module md_ctrl
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter bit PERF_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       e_md_op,
    input  logic             e_valid,
    input  logic             flush,
    input  logic [WIDTH-1:0] e_rs,
    input  logic [WIDTH-1:0] e_rt,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    md_if.master             dp,
    output logic [31:0]      perf_busy_cycles
);

    md_state_e state;
    logic      busy;
    logic      issue;
    logic      md_req;
    logic      mt_ok;

    assign busy   = (state == ST_BUSY);
    assign md_req = e_valid && (e_md_op != MD_NONE);
    assign issue  = e_valid && !flush && is_muldiv(e_md_op);
    // mt writes only land while IDLE; in BUSY they are held off by the stall.
    assign mt_ok  = e_valid && !flush && !busy;

    assign dp.md_in_src0  = e_rs;
    assign dp.md_in_src1  = e_rt;
    assign dp.md_in_sign  = (e_md_op == MD_MULT) || (e_md_op == MD_DIV);
    assign dp.md_in_valid = !busy && issue && dp.md_in_ready;
    assign dp.md_out_ready = busy;

    always_comb begin
        dp.md_in_op = DP_IDLE;
        case (e_md_op)
            MD_MULT, MD_MULTU: dp.md_in_op = DP_MUL;
            MD_DIV,  MD_DIVU:  dp.md_in_op = DP_DIV;
            default:           dp.md_in_op = DP_IDLE;
        endcase
    end

    // In IDLE the only stall is a request the datapath cannot take; in BUSY
    // every md op waits, including the completion cycle, so mf reads never
    // see stale HI/LO. flush deliberately does not enter the BUSY term.
    assign md_stall = busy ? md_req : (issue && !dp.md_in_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (dp.md_in_valid) state <= ST_BUSY;
                ST_BUSY: if (dp.md_out_valid) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    md_hilo_regfile #(.WIDTH(WIDTH)) u_hilo (
        .clk     (clk),
        .reset   (reset),
        .res_we  (busy && dp.md_out_valid),
        .res_hi  (dp.md_out_res1),
        .res_lo  (dp.md_out_res0),
        .mthi_we (mt_ok && (e_md_op == MD_MTHI)),
        .mtlo_we (mt_ok && (e_md_op == MD_MTLO)),
        .mt_data (e_rs),
        .hi      (hi_out),
        .lo      (lo_out)
    );

    generate
        if (PERF_EN) begin : g_perf
            logic [31:0] busy_cnt;
            always_ff @(posedge clk) begin
                if (reset)     busy_cnt <= '0;
                else if (busy) busy_cnt <= busy_cnt + 32'd1;
            end
            assign perf_busy_cycles = busy_cnt;
        end else begin : g_no_perf
            assign perf_busy_cycles = '0;
        end
    endgenerate

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  e_md_op;
    logic        e_valid;
    logic        flush;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        md_stall;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] perf_busy_cycles;

    md_if #(.WIDTH(32)) dpif ();

    md_ctrl #(.WIDTH(32), .PERF_EN(1'b1)) dut (
        .clk              (clk),
        .reset            (reset),
        .e_md_op          (e_md_op),
        .e_valid          (e_valid),
        .flush            (flush),
        .e_rs             (e_rs),
        .e_rt             (e_rt),
        .md_stall         (md_stall),
        .hi_out           (hi_out),
        .lo_out           (lo_out),
        .dp               (dpif),
        .perf_busy_cycles (perf_busy_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural datapath stand-in ----------------
    logic        ready_en;
    int          div_lat_force;
    logic        dp_busy;
    int          dp_cnt;
    logic [31:0] dp_r0, dp_r1;
    int          accepts;
    int          busy_obs;

    assign dpif.md_in_ready  = ready_en && !dp_busy;
    assign dpif.md_out_valid = dp_busy && (dp_cnt == 0);
    assign dpif.md_out_res0  = dp_r0;
    assign dpif.md_out_res1  = dp_r1;

    function automatic int dp_lat(input logic [1:0] op);
        if (op == DP_MUL) return 1;
        if (div_lat_force != 0) return div_lat_force;
        return int'($urandom_range(1, 8));
    endfunction

    function automatic logic [63:0] dp_compute(input logic [1:0] op, input logic sign,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb;
        logic [31:0] q, r;
        if (op == DP_MUL) begin
            xa = sign ? {{32{a[31]}}, a} : {32'd0, a};
            xb = sign ? {{32{b[31]}}, b} : {32'd0, b};
            return xa * xb;
        end
        if (sign) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    initial accepts = 0;

    always @(posedge clk) begin
        if (reset) begin
            dp_busy <= 1'b0;
            dp_cnt  <= 0;
        end else if (dp_busy) begin
            if (dp_cnt == 0) begin
                if (dpif.md_out_ready) dp_busy <= 1'b0;
            end else begin
                dp_cnt <= dp_cnt - 1;
            end
        end else if (dpif.md_in_valid && dpif.md_in_ready) begin
            accepts <= accepts + 1;
            dp_busy <= 1'b1;
            dp_cnt  <= dp_lat(dpif.md_in_op) - 1;
            {dp_r1, dp_r0} <= dp_compute(dpif.md_in_op, dpif.md_in_sign,
                                         dpif.md_in_src0, dpif.md_in_src1);
        end
    end

    always @(posedge clk) begin
        if (reset)                  busy_obs <= 0;
        else if (dpif.md_out_ready) busy_obs <= busy_obs + 1;
    end

    // ---------------- reference model (program order) ----------------
    logic [31:0] exp_hi, exp_lo;
    int          exp_accepts;

    task automatic model_exec(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint      sp;
        logic [63:0] up;
        int          sq, sr;
        case (op)
            MD_MULT:  begin sp = longint'($signed(rs)) * longint'($signed(rt));
                            exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
            MD_MULTU: begin up = 64'(rs) * 64'(rt);
                            exp_hi = up[63:32]; exp_lo = up[31:0]; end
            MD_DIV:   begin sq = int'(rs) / int'(rt); sr = int'(rs) % int'(rt);
                            exp_lo = sq; exp_hi = sr; end
            MD_DIVU:  begin exp_lo = rs / rt; exp_hi = rs % rt; end
            MD_MTHI:  exp_hi = rs;
            MD_MTLO:  exp_lo = rs;
            default:  ;
        endcase
    endtask

    // ---------------- checking helpers ----------------
    int checks;
    int errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an instruction and hold it while stalled; returns at a
    // settled point of the cycle in which it proceeds.
    task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic fl, output int stalls);
        e_valid = 1'b1;
        e_md_op = op;
        e_rs    = rs;
        e_rt    = rt;
        flush   = fl;
        stalls  = 0;
        #1;
        while (md_stall && stalls < 64) begin
            @(posedge clk);
            #2;
            stalls++;
        end
        chk("stall_timeout", (stalls >= 64) ? 64'd1 : 64'd0, 64'd0);
    endtask

    task automatic retire();
        @(posedge clk);
        #1;
        e_valid = 1'b0;
        e_md_op = MD_NONE;
        flush   = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          st;
    int          base_busy;
    logic [3:0]  rop;
    logic [31:0] rrs, rrt;
    logic        rfl;
    logic [1:0]  exp_dop;

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; e_valid = 1'b0; e_md_op = MD_NONE; flush = 1'b0;
        e_rs = '0; e_rt = '0; ready_en = 1'b1; div_lat_force = 0;
        exp_hi = '0; exp_lo = '0; exp_accepts = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;

        // reset state
        chk("rst_hi", hi_out, 0);
        chk("rst_lo", lo_out, 0);
        chk("rst_stall", md_stall, 0);
        chk("rst_in_valid", dpif.md_in_valid, 0);
        chk("rst_busy", dpif.md_out_ready, 0);
        chk("rst_perf", perf_busy_cycles, 0);

        // flushed MULTU never issues
        run_op(MD_MULTU, 32'd9, 32'd9, 1'b1, st);
        chk("flush_in_valid", dpif.md_in_valid, 0);
        retire();
        chk("flush_state_idle", dpif.md_out_ready, 0);
        chk("flush_hi", hi_out, exp_hi);
        chk("flush_lo", lo_out, exp_lo);

        // MULT -3 * 5
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, st);
        chk("mult_issue_stall", md_stall, 0);
        chk("mult_in_valid", dpif.md_in_valid, 1);
        chk("mult_in_op", dpif.md_in_op, DP_MUL);
        chk("mult_in_sign", dpif.md_in_sign, 1);
        model_exec(MD_MULT, 32'hFFFF_FFFD, 32'd5); exp_accepts++;
        retire();
        chk("mult_busy", dpif.md_out_ready, 1);
        @(posedge clk); #1;
        chk("mult_hi", hi_out, 32'hFFFF_FFFF);
        chk("mult_lo", lo_out, 32'hFFFF_FFF1);
        chk("mult_accepts", accepts, exp_accepts);

        // MULT held off while the datapath is not ready
        ready_en = 1'b0;
        e_valid = 1'b1; e_md_op = MD_MULT; e_rs = 32'd3; e_rt = 32'd4; flush = 1'b0;
        #1;
        chk("nready_stall", md_stall, 1);
        chk("nready_in_valid", dpif.md_in_valid, 0);
        @(posedge clk); #2;
        chk("nready_idle", dpif.md_out_ready, 0);
        ready_en = 1'b1;
        #1;
        chk("ready_stall", md_stall, 0);
        chk("ready_in_valid", dpif.md_in_valid, 1);
        model_exec(MD_MULT, 32'd3, 32'd4); exp_accepts++;
        retire();

        // DIVU 7/2 then MFLO back-to-back
        div_lat_force = 3;
        run_op(MD_DIVU, 32'd7, 32'd2, 1'b0, st);
        chk("divu_in_op", dpif.md_in_op, DP_DIV);
        chk("divu_in_sign", dpif.md_in_sign, 0);
        model_exec(MD_DIVU, 32'd7, 32'd2); exp_accepts++;
        retire();
        run_op(MD_MFLO, 32'd0, 32'd0, 1'b0, st);
        chk("mflo_stall_cycles", st, 3);
        chk("divu_lo", lo_out, 32'd3);
        chk("divu_hi", hi_out, 32'd1);
        retire();

        // DIV -7/2 and busy-cycle counter
        div_lat_force = 5;
        base_busy = busy_obs;
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, st);
        model_exec(MD_DIV, 32'hFFFF_FFF9, 32'd2); exp_accepts++;
        retire();
        run_op(MD_MFHI, 32'd0, 32'd0, 1'b0, st);
        chk("div_lo", lo_out, 32'hFFFF_FFFD);
        chk("div_hi", hi_out, 32'hFFFF_FFFF);
        chk("div_busy_delta", busy_obs - base_busy, 5);
        chk("perf_count", perf_busy_cycles, busy_obs);
        retire();

        // MTHI then MFHI
        run_op(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, st);
        model_exec(MD_MTHI, 32'h1234_5678, 32'd0);
        retire();
        run_op(MD_MFHI, 32'd0, 32'd0, 1'b0, st);
        chk("mthi_hi", hi_out, 32'h1234_5678);
        retire();

        // MTLO during BUSY is ordered after the divide result
        div_lat_force = 4;
        run_op(MD_DIVU, 32'd100, 32'd7, 1'b0, st);
        model_exec(MD_DIVU, 32'd100, 32'd7); exp_accepts++;
        retire();
        run_op(MD_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0, st);
        chk("mtlo_stall_cycles", st, 4);
        model_exec(MD_MTLO, 32'hCAFE_F00D, 32'd0);
        retire();
        run_op(MD_MFLO, 32'd0, 32'd0, 1'b0, st);
        chk("mtlo_lo", lo_out, 32'hCAFE_F00D);
        chk("mtlo_hi", hi_out, 32'd2);
        retire();

        // reset in the middle of a divide
        div_lat_force = 6;
        run_op(MD_DIV, 32'd100, 32'd3, 1'b0, st);
        exp_accepts++;
        retire();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        e_valid = 1'b1; e_md_op = MD_MFHI;
        #1;
        chk("rstmid_idle", dpif.md_out_ready, 0);
        chk("rstmid_stall", md_stall, 0);
        chk("rstmid_hi", hi_out, 0);
        chk("rstmid_lo", lo_out, 0);
        retire();
        run_op(MD_MULT, 32'd6, 32'd7, 1'b0, st);
        model_exec(MD_MULT, 32'd6, 32'd7); exp_accepts++;
        retire();
        run_op(MD_MFLO, 32'd0, 32'd0, 1'b0, st);
        chk("post_rst_lo", lo_out, 32'd42);
        chk("post_rst_hi", hi_out, 32'd0);
        retire();

        // randomized program against the reference model
        div_lat_force = 0;
        for (int i = 0; i < 200; i++) begin
            rop = 4'($urandom_range(0, 8));
            rrs = $urandom;
            rrt = $urandom;
            if ($urandom_range(0, 3) == 0) rrt = 32'($urandom_range(0, 9));
            if (rrt == 0) rrt = 32'd1;
            if (rop == MD_DIV && rrs == 32'h8000_0000 && rrt == 32'hFFFF_FFFF) rrt = 32'd1;
            rfl = ($urandom_range(0, 7) == 0);
            exp_dop = (rop == MD_MULT || rop == MD_MULTU) ? 2'b01 :
                      (rop == MD_DIV  || rop == MD_DIVU)  ? 2'b10 : 2'b00;
            run_op(rop, rrs, rrt, rfl, st);
            chk("rnd_in_op", dpif.md_in_op, exp_dop);
            chk("rnd_in_valid", dpif.md_in_valid, (is_muldiv(rop) && !rfl) ? 1 : 0);
            if (!rfl && rop == MD_MFHI) chk("rnd_mfhi", hi_out, exp_hi);
            if (!rfl && rop == MD_MFLO) chk("rnd_mflo", lo_out, exp_lo);
            if (!rfl) begin
                model_exec(rop, rrs, rrt);
                if (is_muldiv(rop)) exp_accepts++;
            end
            retire();
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk); #1;
            end
        end

        // drain and final state
        run_op(MD_MFHI, 32'd0, 32'd0, 1'b0, st);
        chk("final_hi", hi_out, exp_hi);
        chk("final_lo", lo_out, exp_lo);
        chk("final_accepts", accepts, exp_accepts);
        chk("final_perf", perf_busy_cycles, busy_obs);
        retire();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
